weight_buffer_ctrl: RTL
=======================

# weight_buffer_ctrl

Ping-pong controller for the weight buffer BRAM. It accepts weight tiles from the DDR read path on an AXI-Stream slave and writes them into one of two banks. On request, it drains a filled bank to the compute array as a fixed-rate valid/last stream. Bank ownership is tracked so that filling of one bank overlaps draining of the other.

## Interface

Parameters:
- B_ADDR, 9: per-bank address width; bank depth is 2^B_ADDR words.
- B_DATA, 64: weight word width.

Ports:
- clk, in, 1: single clock for all logic and for both BRAM ports.
- rstn, in, 1: synchronous reset, active-low.
- cfg_len, in, B_ADDR: tile length minus one (0 means 1 word). Sampled when a fill starts.
- s_axis_tdata, in, B_DATA: incoming weight word.
- s_axis_tvalid, in, 1: word valid.
- s_axis_tlast, in, 1: last word of tile (checked only, see Configuration).
- s_axis_tready, out, 1: controller can accept a word.
- rd_start, in, 1: pulse requesting a drain of the oldest full bank.
- rd_busy, out, 1: a drain is in progress.
- m_data, out, B_DATA: drained weight word.
- m_valid, out, 1: m_data valid.
- m_last, out, 1: final word of the drained tile.
- buf_we, out, 1: BRAM write enable.
- buf_wraddr, out, B_ADDR+1: BRAM write address; MSB is the bank.
- buf_di, out, B_DATA: BRAM write data.
- buf_rdaddr, out, B_ADDR+1: BRAM read address; MSB is the bank.
- buf_do, in, B_DATA: BRAM read data, 1-cycle read latency.
- full_cnt, out, 2: number of banks holding a complete, undrained tile (0..2).
- err, out, 1: sticky tlast-mismatch flag.

## Operation

- State:
  - wr_bank and rd_bank, 1 bit each, both reset to 0.
  - wr_cnt and rd_cnt, B_ADDR bits each.
  - Per-bank latched length len_q[0..1].
  - full_cnt.
- Fill FSM, states F_IDLE and F_FILL:
  - F_IDLE → F_FILL when full_cnt < 2. On this transition, latch cfg_len into len_q[wr_bank] and clear wr_cnt.
  - In F_FILL, s_axis_tready = 1.
  - On each tvalid&&tready beat: buf_we=1, buf_wraddr={wr_bank,wr_cnt}, buf_di=tdata, then wr_cnt++.
  - On the beat where wr_cnt==len_q[wr_bank]: the bank becomes full, wr_bank toggles, and the FSM returns to F_IDLE.
- Drain FSM, states D_IDLE, D_RUN, D_FLUSH:
  - D_IDLE → D_RUN on rd_start when full_cnt > 0. Clear rd_cnt.
  - rd_start in D_RUN, in D_FLUSH, or with full_cnt==0 is ignored (dropped, not queued).
  - In D_RUN, issue buf_rdaddr={rd_bank,rd_cnt} every cycle with rd_cnt++. After issuing rd_cnt==len_q[rd_bank], go to D_FLUSH.
  - D_FLUSH lasts one cycle (the final data returns). Then: bank released, rd_bank toggles, full_cnt decrements, go to D_IDLE.
  - m_valid is the read-issue strobe delayed 1 cycle. m_data = buf_do. m_last is the final-address strobe delayed 1 cycle.
  - The drain side has no backpressure.
- full_cnt arithmetic:
  - +1 on fill completion, −1 on drain release.
  - Both in the same cycle → unchanged.
  - Never exceeds 2, never underflows (guaranteed by the FSM gating).
- Banks are drained in fill order.
- rd_busy = 1 in D_RUN or D_FLUSH.

## Timing

- Reset values:
  - s_axis_tready=0, buf_we=0, m_valid=0, m_last=0, rd_busy=0, full_cnt=0, err=0.
  - buf_wraddr, buf_rdaddr, buf_di, m_data = 0.
- s_axis_tready rises in the first cycle after reset release; the F_IDLE→F_FILL decision is registered.
- tready is a registered-state function; it has no combinational path from tvalid.
- Write path: buf_we/buf_wraddr/buf_di are combinational from the accepted beat and land in the BRAM at that clock edge.
- Drain latency: rd_start at cycle t → first m_valid at t+2. The tile streams len+1 consecutive cycles. m_last is on cycle t+2+len. rd_busy falls at t+3+len.
- Fill complete to drain: a tile whose last beat is at cycle t is drainable by rd_start at t+1.
- A fill may write bank A while bank B is read in the same cycle. The BRAM runs READ_FIRST, so there is no same-address hazard across banks.
- rstn low mid-fill or mid-drain:
  - Both FSMs return to idle, all banks are freed, and in-flight words are discarded.
  - m_valid drops in the reset cycle.

## Configuration

- WBUF_CTRL_TLAST_CHK_EN defined:
  - err is set and held until reset on either mismatch: s_axis_tlast=1 on a beat with wr_cnt≠len_q, or tlast=0 on the final counted beat.
  - The tile still closes on the count.
- Not defined: s_axis_tlast is ignored and err is tied to 0.

## Test plan

- Single tile: cfg_len=7, 8 beats of data i, then rd_start → m_data 0..7 on 8 consecutive cycles starting 2 cycles after rd_start, m_last on word 7, full_cnt goes 0→1→0.
- Ping-pong overlap: cfg_len=511. Fill bank0, then rd_start while bank1 fills at full rate → no tready stall, drain order bank0 then bank1, buf_wraddr MSB=1 while buf_rdaddr MSB=0.
- Full stall: fill two tiles with cfg_len=3 and no drain → full_cnt=2, tready=0. Send rd_start → tready returns the cycle after bank release.
- Ignored start: rd_start with full_cnt=0, and a second rd_start during D_RUN → exactly one tile output, no extra m_valid.
- tlast check (macro defined): cfg_len=3, tlast on beat 2 → err=1 from the next cycle onward, tile still 4 words. Macro undefined → err stays 0.
- Reset mid-drain: rstn=0 for 1 cycle at word 3 of 8 → m_valid=0, full_cnt=0, rd_busy=0. The next fill lands in bank0.

Source files
------------

// File: rtl/weight_buffer_ctrl.sv
// Ping-pong weight buffer controller: AXI-Stream fill into two BRAM banks, fixed-rate drain.
// Optional tlast checking is enabled by defining WBUF_CTRL_TLAST_CHK_EN.
module weight_buffer_ctrl #(
  parameter int B_ADDR = 9,
  parameter int B_DATA = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [B_ADDR-1:0] cfg_len,
  input  logic [B_DATA-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  input  logic              rd_start,
  output logic              rd_busy,
  output logic [B_DATA-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  output logic              buf_we,
  output logic [B_ADDR:0]   buf_wraddr,
  output logic [B_DATA-1:0] buf_di,
  output logic [B_ADDR:0]   buf_rdaddr,
  input  logic [B_DATA-1:0] buf_do,
  output logic [1:0]        full_cnt,
  output logic              err
);

  typedef enum logic [0:0] {F_IDLE = 1'b0, F_FILL = 1'b1} fill_t;
  typedef enum logic [1:0] {D_IDLE = 2'd0, D_RUN = 2'd1, D_FLUSH = 2'd2} drain_t;

  fill_t             fstate;
  drain_t            dstate;
  logic              wr_bank;
  logic              rd_bank;
  logic [B_ADDR-1:0] wr_cnt;
  logic [B_ADDR-1:0] rd_cnt;
  logic [B_ADDR-1:0] len_q [2];
  logic [1:0]        full_q;
  logic              valid_q;
  logic              last_q;

  logic beat;
  logic wr_at_end;
  logic rd_at_end;
  logic fill_done;
  logic drain_rel;

  // Beat qualification and end-of-tile detection for both sides.
  always_comb begin
    beat      = rstn && (fstate == F_FILL) && s_axis_tvalid;
    wr_at_end = (wr_cnt == len_q[wr_bank]);
    rd_at_end = (rd_cnt == len_q[rd_bank]);
    fill_done = beat && wr_at_end;
    drain_rel = (dstate == D_FLUSH);
  end

  // Outputs are gated by rstn so the stream and write port go quiet in the reset cycle itself.
  assign s_axis_tready = rstn && (fstate == F_FILL);
  assign buf_we        = beat;
  assign buf_wraddr    = {wr_bank, wr_cnt};
  assign buf_di        = beat ? s_axis_tdata : {B_DATA{1'b0}};
  assign buf_rdaddr    = {rd_bank, rd_cnt};
  assign m_valid       = rstn && valid_q;
  assign m_last        = rstn && last_q;
  assign m_data        = m_valid ? buf_do : {B_DATA{1'b0}};
  assign rd_busy       = (dstate != D_IDLE);
  assign full_cnt      = full_q;

  // Fill FSM: claims a free bank, latches its length, counts accepted beats.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fstate   <= F_IDLE;
      wr_bank  <= 1'b0;
      wr_cnt   <= {B_ADDR{1'b0}};
      len_q[0] <= {B_ADDR{1'b0}};
      len_q[1] <= {B_ADDR{1'b0}};
    end else begin
      case (fstate)
        F_IDLE: begin
          if (full_q < 2'd2) begin
            fstate         <= F_FILL;
            len_q[wr_bank] <= cfg_len;
            wr_cnt         <= {B_ADDR{1'b0}};
          end
        end
        F_FILL: begin
          if (beat) begin
            if (wr_at_end) begin
              fstate  <= F_IDLE;
              wr_bank <= ~wr_bank;
            end else begin
              wr_cnt <= wr_cnt + B_ADDR'(1);
            end
          end
        end
        default: fstate <= F_IDLE;
      endcase
    end
  end

  // Drain FSM: one read per cycle, then a flush cycle for the final BRAM word before release.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dstate  <= D_IDLE;
      rd_bank <= 1'b0;
      rd_cnt  <= {B_ADDR{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= (dstate == D_RUN);
      last_q  <= (dstate == D_RUN) && rd_at_end;
      case (dstate)
        D_IDLE: begin
          if (rd_start && (full_q != 2'd0)) begin
            dstate <= D_RUN;
            rd_cnt <= {B_ADDR{1'b0}};
          end
        end
        D_RUN: begin
          if (rd_at_end) begin
            dstate <= D_FLUSH;
          end else begin
            rd_cnt <= rd_cnt + B_ADDR'(1);
          end
        end
        D_FLUSH: begin
          dstate  <= D_IDLE;
          rd_bank <= ~rd_bank;
        end
        default: dstate <= D_IDLE;
      endcase
    end
  end

  // Occupancy: simultaneous completion and release cancel out.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      full_q <= 2'd0;
    end else begin
      case ({fill_done, drain_rel})
        2'b10:   full_q <= full_q + 2'd1;
        2'b01:   full_q <= full_q - 2'd1;
        default: full_q <= full_q;
      endcase
    end
  end

`ifdef WBUF_CTRL_TLAST_CHK_EN
  logic err_q;

  // Sticky flag when tlast disagrees with the counted tile end; the tile still closes on count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (beat && (s_axis_tlast != wr_at_end)) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

  assign err = err_q;
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign err          = 1'b0;
`endif

endmodule
